// File: rtl/interrupt_sequencer.sv
// 6502-style interrupt/reset sequencer: T0..T6 stack push and vector fetch for RES/NMI/IRQ/BRK.
// Define NMI_HIJACK_EN to let a pending NMI take over the vector of an IRQ/BRK sequence up to T4.
module interrupt_sequencer (
    input  logic       phi2,
    input  logic       rst,
    input  logic       nmi_n,
    input  logic       irq_n,
    input  logic       brk,
    input  logic       inst_end,
    input  logic       flag_I,
    output logic       busy,
    output logic [2:0] t_state,
    output logic       rw,
    output logic       pch_db,
    output logic       pcl_db,
    output logic       p_db,
    output logic       s_adl,
    output logic       s_dec,
    output logic       b_flag,
    output logic       O_ADL0,
    output logic       O_ADL1,
    output logic       O_ADL2,
    output logic       dl_pcl,
    output logic       dl_pch,
    output logic       set_I,
    output logic       int_done
);

`ifdef NMI_HIJACK_EN
    localparam bit HijackEn = 1'b1;
`else
    localparam bit HijackEn = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6} state_e;
    typedef enum logic [1:0] {SrcRes, SrcNmi, SrcIrq, SrcBrk} src_e;

    state_e state_q, state_d;
    src_e   src_q, src_d;
    src_e   vec_q, vec_d;   // vector class; differs from src_q only after a hijack
    logic   res_pend_q, res_pend_d;
    logic   nmi_pend_q, nmi_pend_d;
    logic   nmi_n_q, nmi_n_d;
    logic   irq_ok;
    logic   early;
    logic [2:0] oadl;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        vec_d      = vec_q;
        res_pend_d = res_pend_q;
        nmi_n_d    = nmi_n;
        irq_ok     = ~irq_n & ~flag_I;
        early      = (state_q == StT0) || (state_q == StT1) || (state_q == StT2) ||
                     (state_q == StT3) || (state_q == StT4);

        nmi_pend_d = nmi_pend_q;
        if (state_q == StT5 && vec_q == SrcNmi) nmi_pend_d = 1'b0;
        // A fresh edge on the clearing cycle must not be lost.
        if (nmi_n_q && !nmi_n) nmi_pend_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (res_pend_q) begin
                    state_d = StT0;
                    src_d   = SrcRes;
                    vec_d   = SrcRes;
                end else if (inst_end && (nmi_pend_q || irq_ok || brk)) begin
                    state_d = StT0;
                    if (nmi_pend_q)  src_d = SrcNmi;
                    else if (irq_ok) src_d = SrcIrq;
                    else             src_d = SrcBrk;
                    vec_d = src_d;
                end
            end
            StT6: begin
                state_d    = StIdle;
                res_pend_d = 1'b0;
            end
            default: state_d = state_e'(state_q + 3'd1);
        endcase

        if (HijackEn && early && nmi_pend_q && (src_q == SrcIrq || src_q == SrcBrk)) begin
            vec_d = SrcNmi;
        end
    end

    always_ff @(posedge phi2) begin
        if (rst) begin
            state_q    <= StIdle;
            src_q      <= SrcRes;
            vec_q      <= SrcRes;
            res_pend_q <= 1'b1;
            nmi_pend_q <= 1'b0;
            nmi_n_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            vec_q      <= vec_d;
            res_pend_q <= res_pend_d;
            nmi_pend_q <= nmi_pend_d;
            nmi_n_q    <= nmi_n_d;
        end
    end

    always_comb begin
        busy     = (state_q != StIdle);
        t_state  = (state_q == StIdle) ? 3'd0 : 3'(state_q - 3'd1);
        rw       = 1'b1;
        pch_db   = 1'b0;
        pcl_db   = 1'b0;
        p_db     = 1'b0;
        s_adl    = 1'b0;
        s_dec    = 1'b0;
        b_flag   = 1'b0;
        dl_pcl   = 1'b0;
        dl_pch   = 1'b0;
        set_I    = 1'b0;
        int_done = 1'b0;
        oadl     = 3'b111;

        unique case (state_q)
            StT2, StT3, StT4: begin
                s_adl = 1'b1;
                s_dec = 1'b1;
                // Reset walks the stack pointer but never writes memory.
                if (src_q != SrcRes) begin
                    rw     = 1'b0;
                    pch_db = (state_q == StT2);
                    pcl_db = (state_q == StT3);
                    p_db   = (state_q == StT4);
                    b_flag = (state_q == StT4) && (src_q == SrcBrk);
                end
            end
            StT5: begin
                dl_pcl = 1'b1;
                set_I  = 1'b1;
                case (vec_q)
                    SrcNmi:  oadl = 3'b010;
                    SrcRes:  oadl = 3'b100;
                    default: oadl = 3'b110;
                endcase
            end
            StT6: begin
                dl_pch   = 1'b1;
                int_done = 1'b1;
                case (vec_q)
                    SrcNmi:  oadl = 3'b011;
                    SrcRes:  oadl = 3'b101;
                    default: oadl = 3'b111;
                endcase
            end
            default: ;
        endcase

        {O_ADL2, O_ADL1, O_ADL0} = oadl;
    end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset (clock phi2, reset rst).
REQ-002 The block SHALL have these ports:
- phi2  in  1  clock; all state updates on posedge
- rst  in  1  synchronous active-high reset
- nmi_n  in  1  NMI pin, active-low, falling-edge sensitive
- irq_n  in  1  IRQ pin, active-low, level sensitive
- brk  in  1  BRK opcode decoded; valid with inst_end
- inst_end  in  1  instruction-boundary strobe from decoder
- flag_I  in  1  status register I bit
- busy  out  1  sequence in progress (T0..T6)
- t_state  out  3  current step, 0..6; 0 when idle
- rw  out  1  1 = read, 0 = write
- pch_db, pcl_db, p_db  out  1 each  drive PCH / PCL / P onto DB
- s_adl  out  1  drive stack pointer onto ADL
- s_dec  out  1  decrement stack pointer this cycle
- b_flag  out  1  B bit value for pushed P
- O_ADL0, O_ADL1, O_ADL2  out  1 each  active-low vector pull-downs on ADL bits 0..2
- dl_pcl, dl_pch  out  1 each  load input data latch into PCL / PCH
- set_I  out  1  set I flag
- int_done  out  1  one-cycle pulse, sequence complete

Function
REQ-003 State register SHALL be IDLE, T0..T6; all outputs SHALL be decoded from registered state and source (Moore).
REQ-004 Source priority SHALL be RES > NMI > IRQ > BRK; source SHALL be latched on entry to T0.
REQ-005 nmi_pend SHALL be set on the posedge where registered nmi_n is 1 and current nmi_n is 0; it SHALL be cleared at T5 when the NMI vector is used; a new edge on that same cycle SHALL win (stays set).
REQ-006 IRQ SHALL be taken only while irq_n=0 and flag_I=0 at the boundary; irq_n SHALL NOT be latched.
REQ-007 From IDLE, T0 SHALL be entered on the posedge after inst_end=1 with any qualified source (nmi_pend, unmasked IRQ, brk); res_pend SHALL start T0 without inst_end.
REQ-008 T0, T1: rw=1, no strobes (dummy reads).
REQ-009 T2: s_adl=1, s_dec=1, pch_db=1, rw=0. T3: same with pcl_db=1 instead. T4: same with p_db=1; b_flag=1 only when the source is BRK.
REQ-010 For source RES, T2..T4 SHALL keep rw=1 and all *_db=0, s_adl=1 and s_dec=1.
REQ-011 T5: rw=1, dl_pcl=1, set_I=1, O_ADL* drive the vector low byte; T6: rw=1, dl_pch=1, int_done=1, O_ADL* drive low byte+1; T6 SHALL always be followed by IDLE.
REQ-012 Vector low bytes (ADL precharged FF, ADH left FF): NMI FA (O_ADL0=0, O_ADL2=0), RES FC (O_ADL0=0, O_ADL1=0), IRQ/BRK FE (O_ADL0=0); T6 bytes FB (O_ADL2=0), FD (O_ADL1=0), FF (none).
REQ-013 inst_end, brk and irq_n SHALL be ignored while busy=1.
REQ-014 O_ADL* SHALL be 1 in all states other than T5, T6.

Reset
REQ-015 rst=1 SHALL force state IDLE, res_pend=1, nmi_pend=0, registered nmi_n=1, source=RES; outputs: busy=0, t_state=0, rw=1, O_ADL*=1, all other outputs 0.
REQ-016 rst asserted mid-sequence SHALL abort it on that posedge; the RES sequence SHALL begin on the first posedge with rst=0; res_pend SHALL clear at T6.

Configuration
REQ-017 Macro NMI_HIJACK_EN: when defined, nmi_pend=1 at any posedge during T0..T4 of an IRQ/BRK sequence SHALL switch the vector to NMI; the vector SHALL be frozen at end of T4; b_flag SHALL remain from the original source.
REQ-018 Without NMI_HIJACK_EN, the vector SHALL be fixed at T0 entry; an NMI arriving mid-sequence SHALL stay pending and be taken at the next boundary.

Verification
REQ-019 Release rst, no inputs -> T0..T6 over 7 cycles, rw=1 throughout, T5 O_ADL0=O_ADL1=0, T6 O_ADL1=0, int_done pulse, res_pend cleared.
REQ-020 irq_n=0, flag_I=0, inst_end pulse -> T2/T3/T4 rw=0 with pch_db/pcl_db/p_db, b_flag=0, T5 O_ADL0=0 only, T6 no O_ADL asserted; repeat with flag_I=1 -> stays IDLE.
REQ-021 brk=1 with inst_end, flag_I=1 -> sequence runs, b_flag=1 at T4, vector FE/FF.
REQ-022 BRK sequence, nmi_n falls at T3 -> with NMI_HIJACK_EN: vector FA/FB, b_flag=1, nmi_pend cleared at T5; without: vector FE/FF, NMI sequence starts after next inst_end.
REQ-023 nmi_n and irq_n fall together before inst_end -> NMI taken first; IRQ taken at following boundary if still low; nmi_n held low -> no second NMI.
REQ-024 rst pulsed at T3 of an IRQ sequence -> IDLE with reset output values, then full RES sequence.
